// File: rtl/fifo_rd_unpacker.sv
// -----------------------------------------------------------------------------
// fifo_rd_unpacker
//
// Read-side consumer for the 32-to-128 width-converting async FIFO. Pops wide
// words from the FIFO read port and serialises each word into LANES pixels on
// a valid/ready stream, lane 0 (least significant slice) first. Everything
// runs in the read-clock domain.
//
// A two-word store (cur + nxt) plus one in-flight read covers the FIFO's
// one-cycle read latency, so with a non-empty FIFO and a ready sink the
// stream carries one pixel per clock with no bubbles.
//
// Ports
//   rd_clk         read-domain clock, rising edge
//   rd_rst_n       synchronous active-low reset
//   en             run request
//   flush          one-cycle pulse: drop all held/pending data, go idle
//   fifo_rd_en     FIFO pop (combinational from registers and fifo_rd_empty)
//   fifo_rd_data   FIFO data, valid the cycle after fifo_rd_en
//   fifo_rd_empty  FIFO empty flag
//   pix_valid      pixel valid
//   pix_ready      downstream accept
//   pix_data       current pixel (lane idx of the current word)
//   pix_last_lane  high with the last lane of a word
//   busy           state is not IDLE
//   underflow_cnt  saturating count of starved cycles while running
// -----------------------------------------------------------------------------
module fifo_rd_unpacker #(
    parameter int DIN_WIDTH    = 128,
    parameter int DOUT_WIDTH   = 32,
    parameter int UF_CNT_WIDTH = 16
) (
    input  logic                    rd_clk,
    input  logic                    rd_rst_n,
    input  logic                    en,
    input  logic                    flush,
    output logic                    fifo_rd_en,
    input  logic [DIN_WIDTH-1:0]    fifo_rd_data,
    input  logic                    fifo_rd_empty,
    output logic                    pix_valid,
    input  logic                    pix_ready,
    output logic [DOUT_WIDTH-1:0]   pix_data,
    output logic                    pix_last_lane,
    output logic                    busy,
    output logic [UF_CNT_WIDTH-1:0] underflow_cnt
);

    localparam int LANES = DIN_WIDTH / DOUT_WIDTH;
    localparam int IDX_W = (LANES > 1) ? $clog2(LANES) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(LANES - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_DRAIN
    } state_t;

    state_t                  r_state;
    logic [DIN_WIDTH-1:0]    r_cur;
    logic [DIN_WIDTH-1:0]    r_nxt;
    logic                    r_cur_v;
    logic                    r_nxt_v;
    logic                    r_rd_pend;
    logic                    r_started;
    logic [IDX_W-1:0]        r_idx;
    logic [UF_CNT_WIDTH-1:0] r_uf_cnt;

    logic                    w_hs;
    logic                    w_last_hs;
    logic                    w_cap_cur;
    logic                    w_cap_nxt;
    logic [1:0]              w_occ;
    logic                    w_rd_en;
    logic                    w_starved;
    logic [DOUT_WIDTH-1:0]   w_pix;

    // Words held or in flight; a new read is allowed only while below two.
    assign w_occ = 2'(r_cur_v) + 2'(r_nxt_v) + 2'(r_rd_pend);

    // Gated by reset so the FIFO is never popped while the block is held in reset.
    assign w_rd_en = rd_rst_n && (r_state == ST_RUN) && !fifo_rd_empty
                     && !flush && (w_occ < 2'd2);

    assign w_hs      = r_cur_v && pix_ready;
    assign w_last_hs = w_hs && (r_idx == LAST_IDX);

    // The returning word goes straight into cur when cur is empty, or when
    // cur is retiring this cycle with nothing queued behind it; else into nxt.
    assign w_cap_cur = r_rd_pend && (!r_cur_v || (w_last_hs && !r_nxt_v));
    assign w_cap_nxt = r_rd_pend && !w_cap_cur;

    assign w_starved = (r_state == ST_RUN) && r_started && pix_ready && !r_cur_v;

    // NOTE: every signal assigned in always_comb gets a default first, so no
    // path leaves it unassigned and no latch is inferred.
    always_comb begin
        w_pix = '0;
        for (int l = 0; l < LANES; l++) begin
            if (r_idx == IDX_W'(l)) begin
                w_pix = r_cur[l*DOUT_WIDTH +: DOUT_WIDTH];
            end
        end
    end

    assign fifo_rd_en    = w_rd_en;
    assign pix_valid     = r_cur_v;
    assign pix_data      = w_pix;
    assign pix_last_lane = r_cur_v && (r_idx == LAST_IDX);
    assign busy          = (r_state != ST_IDLE);
    assign underflow_cnt = r_uf_cnt;

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples the pre-edge values of the others.
    always_ff @(posedge rd_clk) begin
        if (!rd_rst_n) begin
            r_state   <= ST_IDLE;
            // NOTE: the word registers are reset too, because pix_data must
            // read zero out of reset; they are only two words wide.
            r_cur     <= '0;
            r_nxt     <= '0;
            r_cur_v   <= 1'b0;
            r_nxt_v   <= 1'b0;
            r_rd_pend <= 1'b0;
            r_started <= 1'b0;
            r_idx     <= '0;
            r_uf_cnt  <= '0;
        end else if (flush) begin
            // Drop everything, including a word returning this very cycle.
            r_state   <= ST_IDLE;
            r_cur_v   <= 1'b0;
            r_nxt_v   <= 1'b0;
            r_rd_pend <= 1'b0;
            r_started <= 1'b0;
            r_idx     <= '0;
            r_uf_cnt  <= '0;
        end else begin
            r_rd_pend <= w_rd_en;

            case (r_state)
                ST_IDLE: begin
                    if (en) r_state <= ST_RUN;
                end
                ST_RUN: begin
                    if (!en) r_state <= ST_DRAIN;
                end
                ST_DRAIN: begin
                    if (en) begin
                        r_state <= ST_RUN;
                    end else if (!r_cur_v && !r_nxt_v && !r_rd_pend) begin
                        r_state <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase

            if (r_state == ST_IDLE) begin
                r_started <= 1'b0;
            end else if (w_hs) begin
                r_started <= 1'b1;
            end

            if (w_hs) begin
                r_idx <= (r_idx == LAST_IDX) ? '0 : r_idx + IDX_W'(1);
            end

            if (w_cap_cur) begin
                r_cur   <= fifo_rd_data;
                r_cur_v <= 1'b1;
            end else if (w_last_hs) begin
                if (r_nxt_v) begin
                    r_cur <= r_nxt;
                end
                r_cur_v <= r_nxt_v;
            end

            if (w_cap_nxt) begin
                r_nxt   <= fifo_rd_data;
                r_nxt_v <= 1'b1;
            end else if (w_last_hs && r_nxt_v) begin
                r_nxt_v <= 1'b0;
            end

            if (w_starved && !(&r_uf_cnt)) begin
                r_uf_cnt <= r_uf_cnt + UF_CNT_WIDTH'(1);
            end
        end
    end

endmodule
